// File: rtl/line_engine_pkg.sv
// line_engine_pkg: shared state encoding and default geometry for the line engine
package line_engine_pkg;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_COLOR_W   = 24;
  localparam int DEF_FB_WIDTH  = 800;
  localparam int DEF_FB_HEIGHT = 600;
  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_e;
endpackage

// File: rtl/line_engine_setup.sv
// line_engine_setup: combinational Bresenham setup (steep detect, endpoint swaps, dx/dy/ystep/err); inputs x0/y0/x1/y1, outputs start point, end x, deltas, y direction, initial err
module line_engine_setup #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]        x0_i,
  input  logic [COORD_W-1:0]        y0_i,
  input  logic [COORD_W-1:0]        x1_i,
  input  logic [COORD_W-1:0]        y1_i,
  output logic                      steep_o,
  output logic [COORD_W-1:0]        cx_o,
  output logic [COORD_W-1:0]        cy_o,
  output logic [COORD_W-1:0]        xe_o,
  output logic [COORD_W-1:0]        dx_o,
  output logic [COORD_W-1:0]        dy_o,
  output logic                      yneg_o,
  output logic signed [COORD_W+1:0] err_o
);
  logic [COORD_W-1:0] adx, ady, ax0, ay0, ax1, ay1, by1;
  logic               swap;
  always_comb begin
    adx     = x1_i >= x0_i ? x1_i - x0_i : x0_i - x1_i;
    ady     = y1_i >= y0_i ? y1_i - y0_i : y0_i - y1_i;
    steep_o = ady > adx;
    ax0     = steep_o ? y0_i : x0_i;
    ay0     = steep_o ? x0_i : y0_i;
    ax1     = steep_o ? y1_i : x1_i;
    ay1     = steep_o ? x1_i : y1_i;
    swap    = ax0 > ax1;
    cx_o    = swap ? ax1 : ax0;
    cy_o    = swap ? ay1 : ay0;
    xe_o    = swap ? ax0 : ax1;
    by1     = swap ? ay0 : ay1;
    dx_o    = xe_o - cx_o;
    dy_o    = by1 >= cy_o ? by1 - cy_o : cy_o - by1;
    yneg_o  = !(cy_o < by1);
    err_o   = $signed({2'b00, dx_o >> 1});
  end
endmodule

// File: rtl/line_engine.sv
// line_engine: CPU-programmed Bresenham line rasteriser; register/trigger command port in, clipped pixel stream (valid/ready) out
module line_engine
  import line_engine_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int FB_WIDTH  = DEF_FB_WIDTH,
  parameter int FB_HEIGHT = DEF_FB_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               line_ready,
  input  logic [31:0]        line_color,
  input  logic [COORD_W-1:0] line_point,
  input  logic               line_color_valid,
  input  logic               line_x0_valid,
  input  logic               line_y0_valid,
  input  logic               line_x1_valid,
  input  logic               line_y1_valid,
  input  logic               line_trigger,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COLOR_W-1:0] pix_color
);
  localparam int ERR_W = COORD_W + 2;
  state_e                    state_q;
  logic [COORD_W-1:0]        x0_q, y0_q, x1_q, y1_q, cx_q, cy_q, xe_q, dx_q, dy_q, cy_d;
  logic [COLOR_W-1:0]        color_q;
  logic                      steep_q, yneg_q, inb;
  logic signed [ERR_W-1:0]   err_q, err_d, err_dec;
  logic                      s_steep, s_yneg;
  logic [COORD_W-1:0]        s_cx, s_cy, s_xe, s_dx, s_dy;
  logic signed [ERR_W-1:0]   s_err;
  logic                      unused_color;
  assign unused_color = ^line_color[31:COLOR_W];
  line_engine_setup #(.COORD_W(COORD_W)) u_setup (
    .x0_i(x0_q), .y0_i(y0_q), .x1_i(x1_q), .y1_i(y1_q),
    .steep_o(s_steep), .cx_o(s_cx), .cy_o(s_cy), .xe_o(s_xe),
    .dx_o(s_dx), .dy_o(s_dy), .yneg_o(s_yneg), .err_o(s_err)
  );
  always_comb begin
    pix_x      = steep_q ? cy_q : cx_q;
    pix_y      = steep_q ? cx_q : cy_q;
    pix_color  = color_q;
    inb        = 32'(pix_x) < FB_WIDTH && 32'(pix_y) < FB_HEIGHT;
    pix_valid  = state_q == DRAW && inb;
    line_ready = state_q == IDLE;
    err_dec    = err_q - $signed({2'b00, dy_q});
    err_d      = err_dec[ERR_W-1] ? err_dec + $signed({2'b00, dx_q}) : err_dec;
    cy_d       = err_dec[ERR_W-1] ? (yneg_q ? cy_q - COORD_W'(1) : cy_q + COORD_W'(1)) : cy_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {x0_q, y0_q, x1_q, y1_q, cx_q, cy_q, xe_q, dx_q, dy_q} <= '0;
      color_q <= '0;
      steep_q <= 1'b0;
      yneg_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (line_color_valid) color_q <= line_color[COLOR_W-1:0];
          if (line_x0_valid) x0_q <= line_point;
          if (line_y0_valid) y0_q <= line_point;
          if (line_x1_valid) x1_q <= line_point;
          if (line_y1_valid) y1_q <= line_point;
          if (line_trigger) state_q <= SETUP;
        end
        SETUP: begin
          steep_q <= s_steep;
          cx_q    <= s_cx;
          cy_q    <= s_cy;
          xe_q    <= s_xe;
          dx_q    <= s_dx;
          dy_q    <= s_dy;
          yneg_q  <= s_yneg;
          err_q   <= s_err;
          state_q <= DRAW;
        end
        DRAW: begin
          // clipped pixels advance without waiting for the sink
          if (!inb || pix_ready) begin
            if (cx_q == xe_q) state_q <= IDLE;
            else begin
              cx_q  <= cx_q + COORD_W'(1);
              cy_q  <= cy_d;
              err_q <= err_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed checks of line_engine rasterisation, timing, backpressure, clipping, busy writes and reset
module tb_line_engine;
  logic        clk = 1'b0, rst;
  logic        line_ready, line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid, line_trigger;
  logic [31:0] line_color;
  logic [9:0]  line_point, pix_x, pix_y;
  logic        pix_valid, pix_ready;
  logic [23:0] pix_color;
  int          checks = 0, errors = 0, first_c, done_c;
  int          gx[$], gy[$], gc[$];
  always #5 clk = ~clk;
  line_engine dut (
    .clk(clk), .rst(rst), .line_ready(line_ready), .line_color(line_color), .line_point(line_point),
    .line_color_valid(line_color_valid), .line_x0_valid(line_x0_valid), .line_y0_valid(line_y0_valid),
    .line_x1_valid(line_x1_valid), .line_y1_valid(line_y1_valid), .line_trigger(line_trigger),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int sel, input logic [9:0] v);
    line_point = v;
    line_x0_valid = sel == 0;
    line_y0_valid = sel == 1;
    line_x1_valid = sel == 2;
    line_y1_valid = sel == 3;
    tick;
    {line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid} = '0;
  endtask
  task automatic set_line(input logic [9:0] x0, y0, x1, y1, input logic [31:0] col);
    line_color = col;
    line_color_valid = 1'b1;
    wr(0, x0);
    line_color_valid = 1'b0;
    wr(1, y0);
    wr(2, x1);
    wr(3, y1);
  endtask
  task automatic go;
    line_trigger = 1'b1;
    tick;
    line_trigger = 1'b0;
    check("ready_T1", 32'(line_ready), 0);
    check("valid_T1", 32'(pix_valid), 0);
    tick;
  endtask
  task automatic draw(input logic [15:0] pat, input int plen, input bit inj);
    int hx = 0, hy = 0, hc = 0;
    bit held = 0;
    gx.delete(); gy.delete(); gc.delete();
    first_c = -1;
    done_c = -1;
    for (int c = 0; c < 60; c++) begin
      pix_ready = c < plen ? pat[c] : 1'b1;
      line_point = inj && c == 1 ? 10'd100 : line_point;
      line_x1_valid = inj && c == 1;
      #1;
      if (line_ready) begin
        done_c = c;
        break;
      end
      if (pix_valid) begin
        if (first_c < 0) first_c = c;
        if (held) begin
          check("stable_x", 32'(pix_x), hx);
          check("stable_y", 32'(pix_y), hy);
          check("stable_c", 32'(pix_color), hc);
        end
        if (pix_ready) begin
          gx.push_back(int'(pix_x)); gy.push_back(int'(pix_y)); gc.push_back(int'(pix_color));
          held = 0;
        end else begin
          held = 1; hx = int'(pix_x); hy = int'(pix_y); hc = int'(pix_color);
        end
      end
      tick;
    end
    pix_ready = 1'b0;
    line_x1_valid = 1'b0;
    check("line_done", 32'(line_ready), 1);
  endtask
  task automatic exp_pix(input string tag, input int i, input int x, input int y, input int c);
    check($sformatf("%s_x%0d", tag, i), i < gx.size() ? gx[i] : -1, x);
    check($sformatf("%s_y%0d", tag, i), i < gy.size() ? gy[i] : -1, y);
    check($sformatf("%s_c%0d", tag, i), i < gc.size() ? gc[i] : -1, c);
  endtask
  initial begin
    int sx[6] = '{0, 0, 1, 1, 2, 2};
    int sy[6] = '{0, 1, 2, 3, 4, 5};
    rst = 1'b1;
    {line_color_valid, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid, line_trigger, pix_ready} = '0;
    line_color = '0;
    line_point = '0;
    tick;
    tick;
    check("rst_ready", 32'(line_ready), 1);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_x", 32'(pix_x), 0);
    check("rst_y", 32'(pix_y), 0);
    check("rst_color", 32'(pix_color), 0);
    rst = 1'b0;
    tick;
    set_line(0, 0, 3, 0, 32'hFF0000);
    go;
    draw(16'h0, 0, 0);
    check("horiz_n", gx.size(), 4);
    check("horiz_first", first_c, 0);
    check("horiz_ready", done_c, 4);
    for (int i = 0; i < 4; i++) exp_pix("horiz", i, i, 0, 32'hFF0000);
    set_line(2, 5, 0, 0, 32'h00AB12);
    go;
    draw(16'h0, 0, 0);
    check("steep_n", gx.size(), 6);
    for (int i = 0; i < 6; i++) exp_pix("steep", i, sx[i], sy[i], 32'h00AB12);
    set_line(0, 0, 3, 0, 32'hFF0000);
    go;
    draw(16'b111_0100, 7, 0);
    check("bp_n", gx.size(), 4);
    check("bp_ready", done_c, 7);
    for (int i = 0; i < 4; i++) exp_pix("bp", i, i, 0, 32'hFF0000);
    set_line(5, 7, 5, 7, 32'h123456);
    go;
    draw(16'h0, 0, 0);
    check("zero_n", gx.size(), 1);
    check("zero_ready", done_c, 1);
    exp_pix("zero", 0, 5, 7, 32'h123456);
    set_line(798, 10, 801, 10, 32'h0000FF);
    go;
    draw(16'h0, 0, 0);
    check("clip_n", gx.size(), 2);
    check("clip_ready", done_c, 4);
    exp_pix("clip", 0, 798, 10, 32'hFF);
    exp_pix("clip", 1, 799, 10, 32'hFF);
    set_line(0, 0, 3, 0, 32'h777777);
    go;
    draw(16'h0, 0, 1);
    check("busy_n", gx.size(), 4);
    for (int i = 0; i < 4; i++) exp_pix("busy", i, i, 0, 32'h777777);
    set_line(4, 4, 9, 6, 32'hABCDEF);
    go;
    pix_ready = 1'b1;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    pix_ready = 1'b0;
    check("mrst_valid", 32'(pix_valid), 0);
    check("mrst_ready", 32'(line_ready), 1);
    check("mrst_x", 32'(pix_x), 0);
    check("mrst_color", 32'(pix_color), 0);
    go;
    draw(16'h0, 0, 0);
    check("mrst_n", gx.size(), 1);
    exp_pix("mrst", 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
